// File: rtl/fmul_sched.sv
// Round-robin issue scheduler sharing one pipelined fmul between requesters,
// with id tracking and a credit-checked result FIFO.
module fmul_sched #(
   parameter  int NREQ  = 2,
   parameter  int LAT   = 2,
   parameter  int DEPTH = 4,
   parameter  int TAGW  = 5,
   localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NREQ-1:0]        req_valid,
   output logic [NREQ-1:0]        req_ready,
   input  logic [NREQ*32-1:0]     req_a,
   input  logic [NREQ*32-1:0]     req_b,
   input  logic [NREQ*TAGW-1:0]   req_tag,
   output logic [31:0]            mul_a,
   output logic [31:0]            mul_b,
   output logic                   mul_flag,
   output logic [TAGW-1:0]        mul_addr,
   input  logic [31:0]            mul_result,
   input  logic                   mul_flag_o,
   input  logic [TAGW-1:0]        mul_addr_o,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic [31:0]            res_data,
   output logic [TAGW-1:0]        res_tag,
   output logic [IDW-1:0]         res_id,
   output logic                   err
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int FW = $clog2(LAT + 1);

   logic [NREQ-1:0][31:0]   a_arr;
   logic [NREQ-1:0][31:0]   b_arr;
   logic [NREQ-1:0][TAGW-1:0] t_arr;

   logic [IDW-1:0]  rr_ptr;
   logic [IDW-1:0]  gnt_id;
   logic [IDW-1:0]  cand;
   logic            gnt_any;
   logic            can_issue;

   logic [FW-1:0]   inflight;
   logic [FW-1:0]   drain;
   logic [LAT-1:0]  pipe_v;
   logic [IDW-1:0]  pipe_id [LAT];

   logic [CW-1:0]   fifo_cnt;
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [31:0]     mem_data [DEPTH];
   logic [TAGW-1:0] mem_tag  [DEPTH];
   logic [IDW-1:0]  mem_id   [DEPTH];

   logic            issue;
   logic            push;
   logic            pop;

   assign a_arr = req_a;
   assign b_arr = req_b;
   assign t_arr = req_tag;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Credit check ignores a same-cycle pop, so it is conservative.
   assign can_issue = ((int'(fifo_cnt) + int'(inflight)) < DEPTH)
                      && (drain == '0) && !rst;

   always_comb begin
      gnt_any = 1'b0;
      gnt_id  = '0;
      cand    = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = IDW'((int'(rr_ptr) + k) % NREQ);
         if (!gnt_any && req_valid[cand]) begin
            gnt_any = 1'b1;
            gnt_id  = cand;
         end
      end
   end

   always_comb begin
      req_ready = '0;
      mul_a     = '0;
      mul_b     = '0;
      mul_addr  = '0;
      if (gnt_any && can_issue) begin
         req_ready[gnt_id] = 1'b1;
         mul_a    = a_arr[gnt_id];
         mul_b    = b_arr[gnt_id];
         mul_addr = t_arr[gnt_id];
      end
   end

   assign mul_flag = |req_ready;
   assign issue    = mul_flag;
   // Returns during the post-reset drain window are stale and dropped.
   assign push     = mul_flag_o && (drain == '0);
   assign pop      = res_valid && res_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr   <= '0;
         inflight <= '0;
         drain    <= FW'(LAT);
         pipe_v   <= '0;
         for (int i = 0; i < LAT; i++) pipe_id[i] <= '0;
         fifo_cnt <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         err      <= 1'b0;
      end else begin
         if (drain != '0) drain <= drain - 1'b1;

         if (issue)
            rr_ptr <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;

         pipe_v[0]  <= issue;
         pipe_id[0] <= gnt_id;
         for (int i = 1; i < LAT; i++) begin
            pipe_v[i]  <= pipe_v[i-1];
            pipe_id[i] <= pipe_id[i-1];
         end

         if ((drain == '0) && (pipe_v[LAT-1] != mul_flag_o)) err <= 1'b1;

         if (issue && !push)
            inflight <= inflight + 1'b1;
         else if (!issue && push && (inflight != '0))
            inflight <= inflight - 1'b1;

         if (push) wr_ptr <= nxt(wr_ptr);
         if (pop)  rd_ptr <= nxt(rd_ptr);

         if (push && !pop)
            fifo_cnt <= fifo_cnt + 1'b1;
         else if (!push && pop)
            fifo_cnt <= fifo_cnt - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && push) begin
         mem_data[wr_ptr] <= mul_result;
         mem_tag[wr_ptr]  <= mul_addr_o;
         mem_id[wr_ptr]   <= pipe_id[LAT-1];
      end
   end

   assign res_valid = (fifo_cnt != '0);
   assign res_data  = mem_data[rd_ptr];
   assign res_tag   = mem_tag[rd_ptr];
   assign res_id    = mem_id[rd_ptr];

endmodule
